// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-port arbiter states, owner codes
// and the line width shared with the fetch line buffers.
package cpu_pkg;

   localparam int ADDR_W_DFLT = 32;
   localparam int LINE_W_DFLT = 128;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_IF_BUSY = 2'b01,
      ARB_DM_BUSY = 2'b10,
      ARB_IF_DROP = 2'b11
   } arb_st_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_DM   = 2'b10
   } arb_own_t;

   // DM has priority unless IF has been starved for too long.
   function automatic arb_own_t arb_pick(
      input logic if_ok,
      input logic dm_ok,
      input logic starved
   );
      arb_own_t own;
      own = OWN_NONE;
      if (if_ok && (!dm_ok || starved))
         own = OWN_IF;
      else if (dm_ok)
         own = OWN_DM;
      return own;
   endfunction

endpackage

// File: rtl/mem_port_arb_starve_cnt.sv
// Saturating count of DM grants taken while IF is waiting.
// Clear wins over increment.
module arb_starve_cnt #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   logic [2:0] cnt;

   assign at_max = (cnt == 3'(MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 3'd0;
      else if (clr)
         cnt <= 3'd0;
      else if (inc && !at_max)
         cnt <= cnt + 3'd1;
   end

endmodule

// File: rtl/mem_port_arb.sv
// Single memory port arbiter between IF line refills and the DM stage.
// Holds the bus for a whole transaction and drops flushed IF data.
import cpu_pkg::*;

module mem_port_arb #(
   parameter int ADDR_W     = ADDR_W_DFLT,
   parameter int LINE_W     = LINE_W_DFLT,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                flush,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [LINE_W-1:0]   dm_wdata,
   input  logic [LINE_W/8-1:0] dm_be,
   input  logic                mem_ack,
   input  logic [LINE_W-1:0]   mem_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [LINE_W-1:0]   mem_wdata,
   output logic [LINE_W/8-1:0] mem_be,
   output logic                if_ack,
   output logic [LINE_W-1:0]   if_rdata,
   output logic                dm_ack,
   output logic [LINE_W-1:0]   dm_rdata,
   output logic [1:0]          curr_st
);

   arb_st_t  st;
   arb_own_t pick;
   logic     idle;
   logic     if_ok;
   logic     at_max;
   logic     gnt_if;
   logic     gnt_dm;
   logic     cnt_inc;
   logic     cnt_clr;

   assign idle    = (st == ARB_IDLE);
   assign if_ok   = if_req & ~flush;
   assign pick    = arb_pick(if_ok, dm_req, at_max);
   assign gnt_if  = idle & (pick == OWN_IF);
   assign gnt_dm  = idle & (pick == OWN_DM);
   assign cnt_inc = gnt_dm & if_req;
   assign cnt_clr = gnt_if | (idle & ~if_req);

   arb_starve_cnt #(
      .MAX(STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .clr   (cnt_clr),
      .at_max(at_max)
   );

   // A flush in the ack cycle makes the IF line stale.
   assign if_ack   = (st == ARB_IF_BUSY) & mem_ack & ~flush;
   assign dm_ack   = (st == ARB_DM_BUSY) & mem_ack;
   assign if_rdata = mem_rdata;
   assign dm_rdata = mem_rdata;
   assign curr_st  = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ARB_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         unique case (st)
            ARB_IDLE: begin
               unique case (1'b1)
                  gnt_if: begin
                     st       <= ARB_IF_BUSY;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= if_addr;
                     mem_be   <= '1;
                  end
                  gnt_dm: begin
                     st        <= ARB_DM_BUSY;
                     mem_req   <= 1'b1;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     mem_be    <= dm_be;
                  end
                  default: ;
               endcase
            end
            ARB_IF_BUSY: begin
               if (mem_ack) begin
                  st      <= ARB_IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= '0;
               end else if (flush) begin
                  st <= ARB_IF_DROP;
               end
            end
            ARB_IF_DROP, ARB_DM_BUSY: begin
               if (mem_ack) begin
                  st      <= ARB_IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= '0;
               end
            end
            default: st <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a grant scoreboard.
// Expected grants are queued at drive time and popped on mem_req.
module tb_mem_port_arb;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         if_req = 1'b0;
   logic [31:0]  if_addr = '0;
   logic         flush = 1'b0;
   logic         dm_req = 1'b0;
   logic         dm_we = 1'b0;
   logic [31:0]  dm_addr = '0;
   logic [127:0] dm_wdata = '0;
   logic [15:0]  dm_be = '0;
   logic         mem_ack = 1'b0;
   logic [127:0] mem_rdata = '0;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [15:0]  mem_be;
   logic         if_ack;
   logic [127:0] if_rdata;
   logic         dm_ack;
   logic [127:0] dm_rdata;
   logic [1:0]   curr_st;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [1:0]   st;
      logic         we;
      logic [31:0]  addr;
      logic [15:0]  be;
      logic [127:0] wd;
      bit           cwd;
   } gnt_t;

   gnt_t gq[$];

   mem_port_arb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .flush    (flush),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_be    (dm_be),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_be   (mem_be),
      .if_ack   (if_ack),
      .if_rdata (if_rdata),
      .dm_ack   (dm_ack),
      .dm_rdata (dm_rdata),
      .curr_st  (curr_st)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_g(input logic [1:0] s, input logic w,
                         input logic [31:0] a, input logic [15:0] b,
                         input logic [127:0] d, input bit c);
      gnt_t g;
      g.st = s; g.we = w; g.addr = a;
      g.be = b; g.wd = d; g.cwd = c;
      gq.push_back(g);
   endtask

   task automatic pop_g(input string tag);
      gnt_t g;
      if (gq.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_q obs=empty exp=entry", tag);
      end else begin
         g = gq.pop_front();
         chk({tag, "_req"}, mem_req, 1'b1);
         chk({tag, "_st"}, curr_st, g.st);
         chk({tag, "_we"}, mem_we, g.we);
         chk({tag, "_addr"}, mem_addr, g.addr);
         chk({tag, "_be"}, mem_be, g.be);
         if (g.cwd)
            chk({tag, "_wd"}, mem_wdata, g.wd);
      end
   endtask

   task automatic wait_grant(input string tag, input int max);
      int n = 0;
      while (!mem_req && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_gnt"}, mem_req, 1'b1);
   endtask

   initial begin
      // reset
      #3 rst_n = 1'b0;
      #1;
      chk("rst_req", mem_req, 1'b0);
      chk("rst_st", curr_st, 2'b00);
      chk("rst_be", mem_be, 16'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wd", mem_wdata, 128'h0);
      chk("rst_acks", {if_ack, dm_ack}, 2'b00);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // IF alone
      if_req = 1'b1; if_addr = 32'h1000;
      push_g(2'b01, 1'b0, 32'h1000, 16'hFFFF, '0, 1'b0);
      #1 chk("if_c0_req", mem_req, 1'b0);
      tick();
      pop_g("if_g");
      for (int k = 1; k < 4; k++) begin
         chk("if_busy_req", mem_req, 1'b1);
         chk("if_busy_ack", if_ack, 1'b0);
         chk("if_busy_addr", mem_addr, 32'h1000);
         if (k < 3) tick();
      end
      tick();
      mem_ack = 1'b1; mem_rdata = 128'hA5A5_0001_DEAD_BEEF;
      #1;
      chk("if_ack", if_ack, 1'b1);
      chk("if_dm_ack", dm_ack, 1'b0);
      chk("if_rdata", if_rdata, 128'hA5A5_0001_DEAD_BEEF);
      tick();
      mem_ack = 1'b0; if_req = 1'b0;
      #1;
      chk("if_idle_st", curr_st, 2'b00);
      chk("if_idle_req", mem_req, 1'b0);
      chk("if_idle_ack", if_ack, 1'b0);

      // DM byte-masked write
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2040;
      dm_be = 16'h00F0; dm_wdata = 128'h1111_2222_3333_4444;
      push_g(2'b10, 1'b1, 32'h2040, 16'h00F0, 128'h1111_2222_3333_4444, 1'b1);
      tick();
      pop_g("dmw_g");
      dm_wdata = 128'hBAD; dm_addr = 32'hFFFF;
      tick();
      chk("dmw_hold_wd", mem_wdata, 128'h1111_2222_3333_4444);
      chk("dmw_hold_addr", mem_addr, 32'h2040);
      chk("dmw_noack", dm_ack, 1'b0);
      mem_ack = 1'b1;
      #1;
      chk("dmw_ack", dm_ack, 1'b1);
      chk("dmw_if_ack", if_ack, 1'b0);
      tick();
      mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      #1;
      chk("dmw_ack_once", dm_ack, 1'b0);
      chk("dmw_idle_we", mem_we, 1'b0);
      chk("dmw_idle_be", mem_be, 16'h0);

      // both requesting: DM x4 then IF
      dm_addr = 32'h7000; dm_be = 16'h0F0F; if_addr = 32'h8000;
      for (int i = 0; i < 10; i++) begin
         if (i % 5 == 4)
            push_g(2'b01, 1'b0, 32'h8000, 16'hFFFF, '0, 1'b0);
         else
            push_g(2'b10, 1'b0, 32'h7000, 16'h0F0F, '0, 1'b0);
      end
      dm_req = 1'b1; if_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_grant("stv", 4);
         pop_g("stv");
         mem_ack = 1'b1; mem_rdata = 128'(i);
         #1;
         chk("stv_if_ack", if_ack, (i % 5 == 4));
         chk("stv_dm_ack", dm_ack, (i % 5 != 4));
         tick();
         mem_ack = 1'b0;
         #1 chk("stv_idle", mem_req, 1'b0);
      end
      dm_req = 1'b0; if_req = 1'b0;
      tick();

      // flush in IDLE: request ignored
      if_req = 1'b1; if_addr = 32'h3000; flush = 1'b1;
      tick();
      flush = 1'b0; if_req = 1'b0;
      #1 chk("fl_idle_st", curr_st, 2'b00);
      tick();

      // flush 2 cycles in, ack 3 cycles later
      if_req = 1'b1; if_addr = 32'h3000;
      push_g(2'b01, 1'b0, 32'h3000, 16'hFFFF, '0, 1'b0);
      tick();
      pop_g("drop_g");
      tick();
      flush = 1'b1;
      #1 chk("drop_fl_ack", if_ack, 1'b0);
      tick();
      flush = 1'b0; if_addr = 32'h4000;
      #1;
      chk("drop_st", curr_st, 2'b11);
      chk("drop_req", mem_req, 1'b1);
      chk("drop_addr", mem_addr, 32'h3000);
      tick(); tick();
      mem_ack = 1'b1;
      #1;
      chk("drop_noack", if_ack, 1'b0);
      chk("drop_st2", curr_st, 2'b11);
      tick();
      mem_ack = 1'b0;
      push_g(2'b01, 1'b0, 32'h4000, 16'hFFFF, '0, 1'b0);
      #1;
      chk("drop_idle_st", curr_st, 2'b00);
      chk("drop_idle_req", mem_req, 1'b0);
      tick();
      pop_g("regrant");
      mem_ack = 1'b1;
      #1 chk("regrant_ack", if_ack, 1'b1);
      tick();
      mem_ack = 1'b0; if_req = 1'b0;

      // flush coincident with mem_ack in IF_BUSY
      tick();
      if_req = 1'b1; if_addr = 32'h5000;
      push_g(2'b01, 1'b0, 32'h5000, 16'hFFFF, '0, 1'b0);
      tick();
      pop_g("flack_g");
      mem_ack = 1'b1; flush = 1'b1;
      #1 chk("flack_noack", if_ack, 1'b0);
      tick();
      mem_ack = 1'b0; flush = 1'b0; if_req = 1'b0;
      #1 chk("flack_idle", curr_st, 2'b00);
      tick();

      // flush during DM_BUSY
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h6000; dm_be = 16'hFFFF;
      push_g(2'b10, 1'b0, 32'h6000, 16'hFFFF, '0, 1'b0);
      tick();
      pop_g("dmfl_g");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1 chk("dmfl_st", curr_st, 2'b10);
      mem_ack = 1'b1; mem_rdata = 128'hCAFE_F00D;
      #1;
      chk("dmfl_ack", dm_ack, 1'b1);
      chk("dmfl_rdata", dm_rdata, 128'hCAFE_F00D);
      tick();
      mem_ack = 1'b0; dm_req = 1'b0;
      tick();

      // async reset mid DM_BUSY
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h9000;
      dm_be = 16'h000F; dm_wdata = 128'h77;
      tick();
      chk("rdm_st", curr_st, 2'b10);
      mem_ack = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rdm_req", mem_req, 1'b0);
      chk("rdm_we", mem_we, 1'b0);
      chk("rdm_be", mem_be, 16'h0);
      chk("rdm_addr", mem_addr, 32'h0);
      chk("rdm_st0", curr_st, 2'b00);
      chk("rdm_acks", {if_ack, dm_ack}, 2'b00);
      mem_ack = 1'b0;
      tick();
      rst_n = 1'b1;
      push_g(2'b10, 1'b1, 32'h9000, 16'h000F, 128'h77, 1'b1);
      tick();
      pop_g("rdm_g");
      mem_ack = 1'b1;
      #1 chk("rdm_ack", dm_ack, 1'b1);
      tick();
      mem_ack = 1'b0; dm_req = 1'b0;
      #1 chk("rdm_idle", mem_req, 1'b0);
      chk("sb_empty", gq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=done");
      $fatal(1, "timeout");
   end

endmodule
